// File: rtl/l2_banked_data_array_if.sv
// Request/response bundle between the L2 controller and the banked data array.
interface l2_banked_data_array_if #(
    parameter int WIDTH      = 128,
    parameter int INDEX_BITS = 4,
    parameter int WAYS       = 2
);
    localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic                  clear;
    logic                  busy;
    logic                  rd_en;
    logic                  wr_en;
    logic [WAY_BITS-1:0]   rd_way;
    logic [WAY_BITS-1:0]   wr_way;
    logic [INDEX_BITS-1:0] rd_index;
    logic [INDEX_BITS-1:0] wr_index;
    logic [WIDTH/8-1:0]    wmask;
    logic [WIDTH-1:0]      datain;
    logic [WIDTH-1:0]      rdata;
    logic                  rvalid;

    // Controller side: issues requests, observes busy and read data.
    modport master (
        output clear, rd_en, wr_en, rd_way, wr_way, rd_index, wr_index, wmask, datain,
        input  busy, rdata, rvalid
    );

    // Array side: consumes requests, returns busy and read data.
    modport slave (
        input  clear, rd_en, wr_en, rd_way, wr_way, rd_index, wr_index, wmask, datain,
        output busy, rdata, rvalid
    );
endinterface

// File: rtl/l2_banked_data_array.sv
// Multi-way L2 data store: byte-masked writes, registered reads with
// write-first forwarding, and a sweep sequencer that zeroes every line
// after reset or when the controller requests a clear.
module l2_banked_data_array #(
    parameter int WIDTH      = 128,
    parameter int INDEX_BITS = 4,
    parameter int WAYS       = 2
) (
    input logic clk,
    input logic reset,
    l2_banked_data_array_if.slave bus
);
    localparam int DEPTH = 2 ** INDEX_BITS;
    localparam int NBYTES = WIDTH / 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Merge new bytes into an existing line under a per-byte enable mask.
    function automatic logic [WIDTH-1:0] merge_bytes(
        input logic [WIDTH-1:0]  old_line,
        input logic [WIDTH-1:0]  new_line,
        input logic [NBYTES-1:0] mask
    );
        logic [WIDTH-1:0] line;
        line = old_line;
        for (int b = 0; b < NBYTES; b++) begin
            if (mask[b]) begin
                line[b*8 +: 8] = new_line[b*8 +: 8];
            end else begin
                line[b*8 +: 8] = old_line[b*8 +: 8];
            end
        end
        return line;
    endfunction

    logic [WIDTH-1:0]      r_mem [WAYS][DEPTH];
    state_t                r_state;
    logic [INDEX_BITS-1:0] r_cptr;
    logic                  r_busy;
    logic                  r_rvalid;
    logic [WIDTH-1:0]      r_rdata;

    logic                  w_accept;
    logic                  w_wr_way_ok;
    logic                  w_rd_way_ok;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_same_line;
    logic [WIDTH-1:0]      w_wr_line;
    logic [WIDTH-1:0]      w_rd_line;

    // Request qualification, write merge and write-first read path.
    always_comb begin
        w_accept    = (r_state == ST_IDLE) && !bus.clear;
        w_wr_way_ok = int'(bus.wr_way) < WAYS;
        w_rd_way_ok = int'(bus.rd_way) < WAYS;
        w_wr_ok     = w_accept && bus.wr_en && w_wr_way_ok;
        w_rd_ok     = w_accept && bus.rd_en;
        w_same_line = (bus.rd_way == bus.wr_way) && (bus.rd_index == bus.wr_index);
        w_wr_line   = '0;
        w_rd_line   = '0;
        if (w_wr_way_ok) begin
            w_wr_line = merge_bytes(r_mem[bus.wr_way][bus.wr_index], bus.datain, bus.wmask);
        end else begin
            w_wr_line = '0;
        end
        if (!w_rd_way_ok) begin
            w_rd_line = '0;
        end else if (w_wr_ok && w_same_line) begin
            w_rd_line = w_wr_line;
        end else begin
            w_rd_line = r_mem[bus.rd_way][bus.rd_index];
        end
    end

    // Storage update: sweep zeroes one set across all ways, else accepted write.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            for (int w = 0; w < WAYS; w++) begin
                r_mem[w][r_cptr] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[bus.wr_way][bus.wr_index] <= w_wr_line;
        end
    end

    // Sweep/idle sequencer with registered busy, rvalid and rdata.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_CLEAR;
            r_cptr   <= '0;
            r_busy   <= 1'b1;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_rvalid <= 1'b0;
                    if (bus.clear) begin
                        r_cptr <= '0;
                        r_busy <= 1'b1;
                    end else if (r_cptr == INDEX_BITS'(DEPTH - 1)) begin
                        r_state <= ST_IDLE;
                        r_cptr  <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cptr <= r_cptr + INDEX_BITS'(1);
                        r_busy <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bus.clear) begin
                        r_state  <= ST_CLEAR;
                        r_cptr   <= '0;
                        r_busy   <= 1'b1;
                        r_rvalid <= 1'b0;
                    end else begin
                        r_busy   <= 1'b0;
                        r_rvalid <= w_rd_ok;
                        if (w_rd_ok) begin
                            r_rdata <= w_rd_line;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_CLEAR;
                    r_cptr   <= '0;
                    r_busy   <= 1'b1;
                    r_rvalid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.rvalid = r_rvalid;
    assign bus.rdata  = r_rdata;
endmodule

// File: tb/tb_l2_banked_data_array.sv
// Randomized scoreboard bench for l2_banked_data_array (3 ways, 16 sets, 128-bit lines).
module tb_l2_banked_data_array;
    localparam int W     = 128;
    localparam int IB    = 4;
    localparam int NW    = 3;
    localparam int DEPTH = 16;
    localparam int NB    = W / 8;

    typedef struct {
        int           due;
        logic [W-1:0] data;
    } exp_t;

    logic clk;
    logic reset;

    l2_banked_data_array_if #(.WIDTH(W), .INDEX_BITS(IB), .WAYS(NW)) bus ();

    l2_banked_data_array #(.WIDTH(W), .INDEX_BITS(IB), .WAYS(NW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference model state
    logic [W-1:0] ref_mem [NW][DEPTH];
    int           left;
    int           cyc;
    logic         m_busy;
    logic [W-1:0] m_hold;
    exp_t         sb_q[$];
    bit           mon_en;

    int n_pass;
    int n_chk;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic zero_ref();
        for (int w = 0; w < NW; w++)
            for (int i = 0; i < DEPTH; i++)
                ref_mem[w][i] = '0;
    endtask

    task automatic set_idle();
        bus.clear    = 1'b0;
        bus.rd_en    = 1'b0;
        bus.wr_en    = 1'b0;
        bus.rd_way   = '0;
        bus.wr_way   = '0;
        bus.rd_index = '0;
        bus.wr_index = '0;
        bus.wmask    = '0;
        bus.datain   = '0;
    endtask

    // One clock: model reacts to current inputs, then the edge happens.
    task automatic step();
        exp_t e;
        logic [W-1:0] line;
        if (reset) begin
            left = DEPTH;
            zero_ref();
        end else if (left > 0) begin
            if (bus.clear) left = DEPTH;
            else left = left - 1;
        end else if (bus.clear) begin
            left = DEPTH;
            zero_ref();
        end else begin
            if (bus.wr_en && int'(bus.wr_way) < NW) begin
                line = ref_mem[bus.wr_way][bus.wr_index];
                for (int b = 0; b < NB; b++)
                    if (bus.wmask[b]) line[b*8 +: 8] = bus.datain[b*8 +: 8];
                ref_mem[bus.wr_way][bus.wr_index] = line;
            end
            if (bus.rd_en) begin
                e.due  = cyc + 1;
                e.data = (int'(bus.rd_way) < NW) ? ref_mem[bus.rd_way][bus.rd_index] : '0;
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        cyc    = cyc + 1;
        m_busy = (left > 0);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Asynchronous reset between edges; outputs must drop to reset values at once.
    task automatic async_reset();
        reset = 1'b1;
        zero_ref();
        sb_q.delete();
        left   = DEPTH;
        m_busy = 1'b1;
        m_hold = '0;
        #1;
        chk("rst_busy", W'(bus.busy), W'(1'b1));
        chk("rst_rvalid", W'(bus.rvalid), W'(1'b0));
        chk("rst_rdata", bus.rdata, '0);
    endtask

    task automatic rd(input int way, input int idx);
        bus.rd_en    = 1'b1;
        bus.rd_way   = 2'(way);
        bus.rd_index = 4'(idx);
    endtask

    task automatic wr(input int way, input int idx, input logic [W-1:0] d, input logic [NB-1:0] m);
        bus.wr_en    = 1'b1;
        bus.wr_way   = 2'(way);
        bus.wr_index = 4'(idx);
        bus.datain   = d;
        bus.wmask    = m;
    endtask

    // Monitor: busy every cycle, pop scoreboard on rvalid, hold check otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("busy", W'(bus.busy), W'(m_busy));
            if (bus.rvalid) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL spurious_rvalid: got rvalid=1 expected rvalid=0 (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("rdata", bus.rdata, e.data);
                    chk("rd_latency", W'(cyc), W'(e.due));
                    m_hold = e.data;
                end
            end else begin
                chk("rdata_hold", bus.rdata, m_hold);
                if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                    n_chk++;
                    $display("FAIL missing_rvalid: got rvalid=0 expected rvalid=1 (cycle %0d)", cyc);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] l11;
        logic [W-1:0] laa;
        ones   = '1;
        l11    = {NB{8'h11}};
        laa    = {NB{8'hAA}};
        n_pass = 0;
        n_chk  = 0;
        cyc    = 0;
        mon_en = 1'b0;
        m_hold = '0;
        m_busy = 1'b1;
        left   = DEPTH;
        reset  = 1'b1;
        set_idle();
        zero_ref();
        repeat (3) step();
        mon_en = 1'b1;

        // Reset sweep with a read held on [0][5] throughout.
        reset = 1'b0;
        rd(0, 5);
        repeat (DEPTH + 2) step();
        set_idle();

        // Masked write: only byte 0 of [1][3].
        wr(1, 3, ones, 16'h0001); step();
        set_idle(); rd(1, 3); step();
        rd(0, 3); step();
        rd(1, 4); step();

        // Forwarding on [0][7].
        set_idle(); wr(0, 7, l11, 16'hFFFF); step();
        wr(0, 7, laa, 16'hFF00); rd(0, 7); step();
        set_idle(); rd(0, 7); step();

        // Out-of-range way 3.
        set_idle(); wr(3, 3, ones, 16'hFFFF); step();
        set_idle(); rd(3, 3); step();
        rd(1, 3); step();
        rd(2, 3); step();

        // Random traffic with occasional clears.
        for (int n = 0; n < 300; n++) begin
            set_idle();
            if ($urandom_range(0, 1) == 1) wr($urandom_range(0, 3), $urandom_range(0, 15), rnd_line(), 16'($urandom()));
            if ($urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 2) == 0) rd(int'(bus.wr_way), int'(bus.wr_index));
                else rd($urandom_range(0, 3), $urandom_range(0, 15));
            end
            bus.clear = ($urandom_range(0, 39) == 0);
            step();
        end
        set_idle();
        while (m_busy) step();

        // Fill everything, then clear together with a write and a read.
        for (int w = 0; w < NW; w++)
            for (int i = 0; i < DEPTH; i++) begin
                set_idle(); wr(w, i, rnd_line() | W'(1), 16'hFFFF); step();
            end
        set_idle(); wr(0, 2, ones, 16'hFFFF); rd(0, 2); bus.clear = 1'b1; step();
        for (int n = 0; n < DEPTH; n++) begin
            set_idle(); wr(1, n, ones, 16'hFFFF); rd(0, n); step();
        end
        for (int w = 0; w < NW; w++)
            for (int i = 0; i < DEPTH; i++) begin
                set_idle(); rd(w, i); step();
            end

        // Reset during sweep cycle 9, then a full sweep after release.
        set_idle(); wr(2, 9, ones, 16'hFFFF); step();
        set_idle(); rd(2, 9); bus.clear = 1'b1; step();
        set_idle(); rd(2, 9);
        repeat (9) step();
        async_reset();
        repeat (2) step();
        reset = 1'b0;
        repeat (DEPTH + 2) step();
        set_idle(); rd(2, 9); step();
        set_idle(); step();
        step();

        n_chk++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL sb_empty: got %0d pending expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
